// File: rtl/id_ex_if.sv
// ID/EX stage bundle. It carries the decode-side operands and control, the hazard
// controls, the WB bypass write port and the registered EX-side results.
interface id_ex_if #(
  parameter int CTRL_W = 12
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [31:0]       id_instr;
  logic              id_zext;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       gpr_a;
  logic [31:0]       gpr_b;
  logic              wb_reg_write;
  logic [4:0]        wb_num_write;
  logic [31:0]       wb_data;

  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_rs_val;
  logic [31:0]       ex_rt_val;
  logic [31:0]       ex_imm;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_rd;
  logic [4:0]        ex_shamt;
  logic [CTRL_W-1:0] ex_ctrl;

  modport master (
    output stall, flush, id_valid, id_pc, id_instr, id_zext, id_ctrl,
           gpr_a, gpr_b, wb_reg_write, wb_num_write, wb_data,
    input  ex_valid, ex_pc, ex_rs_val, ex_rt_val, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_shamt, ex_ctrl
  );

  modport slave (
    input  stall, flush, id_valid, id_pc, id_instr, id_zext, id_ctrl,
           gpr_a, gpr_b, wb_reg_write, wb_num_write, wb_data,
    output ex_valid, ex_pc, ex_rs_val, ex_rt_val, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_shamt, ex_ctrl
  );
endinterface

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with a same-cycle WB bypass, stall hold
// (with held-operand refresh) and flush bubble. Every output comes straight from a flop.
module id_ex_stage #(
  parameter int CTRL_W = 12
) (
  input  logic    clock,
  input  logic    reset,
  id_ex_if.slave  bus
);
  logic              ex_valid_q,  ex_valid_d;
  logic [31:0]       ex_pc_q,     ex_pc_d;
  logic [31:0]       ex_rs_val_q, ex_rs_val_d;
  logic [31:0]       ex_rt_val_q, ex_rt_val_d;
  logic [31:0]       ex_imm_q,    ex_imm_d;
  logic [4:0]        ex_rs_q,     ex_rs_d;
  logic [4:0]        ex_rt_q,     ex_rt_d;
  logic [4:0]        ex_rd_q,     ex_rd_d;
  logic [4:0]        ex_shamt_q,  ex_shamt_d;
  logic [CTRL_W-1:0] ex_ctrl_q,   ex_ctrl_d;

  logic [4:0]        id_rs, id_rt;
  logic [5:0]        unused_opcode;
  logic              wb_hit_nonzero;

  assign id_rs          = bus.id_instr[25:21];
  assign id_rt          = bus.id_instr[20:16];
  assign unused_opcode  = bus.id_instr[31:26];
  assign wb_hit_nonzero = bus.wb_reg_write && (bus.wb_num_write != 5'd0);

  // Register 0 always reads as zero; the register file does not return a write
  // that happens in the same cycle, so that write is forwarded here.
  function automatic logic [31:0] pick_operand(input logic [4:0]  num,
                                               input logic [31:0] gpr_val,
                                               input logic        wb_hit,
                                               input logic [4:0]  wb_num,
                                               input logic [31:0] wb_val);
    logic [31:0] val;
    if (num == 5'd0)
      val = 32'd0;
    else if (wb_hit && (wb_num == num))
      val = wb_val;
    else
      val = gpr_val;
    return val;
  endfunction

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_pc_d     = ex_pc_q;
    ex_rs_val_d = ex_rs_val_q;
    ex_rt_val_d = ex_rt_val_q;
    ex_imm_d    = ex_imm_q;
    ex_rs_d     = ex_rs_q;
    ex_rt_d     = ex_rt_q;
    ex_rd_d     = ex_rd_q;
    ex_shamt_d  = ex_shamt_q;
    ex_ctrl_d   = ex_ctrl_q;

    if (bus.flush) begin
      ex_valid_d  = 1'b0;
      ex_pc_d     = 32'd0;
      ex_rs_val_d = 32'd0;
      ex_rt_val_d = 32'd0;
      ex_imm_d    = 32'd0;
      ex_rs_d     = 5'd0;
      ex_rt_d     = 5'd0;
      ex_rd_d     = 5'd0;
      ex_shamt_d  = 5'd0;
      ex_ctrl_d   = '0;
    end else if (bus.stall) begin
      // A WB retiring during a long stall must not leave a stale held operand.
      if (wb_hit_nonzero && (bus.wb_num_write == ex_rs_q))
        ex_rs_val_d = bus.wb_data;
      if (wb_hit_nonzero && (bus.wb_num_write == ex_rt_q))
        ex_rt_val_d = bus.wb_data;
    end else begin
      ex_valid_d  = bus.id_valid;
      ex_pc_d     = bus.id_pc;
      ex_rs_val_d = pick_operand(id_rs, bus.gpr_a, bus.wb_reg_write,
                                 bus.wb_num_write, bus.wb_data);
      ex_rt_val_d = pick_operand(id_rt, bus.gpr_b, bus.wb_reg_write,
                                 bus.wb_num_write, bus.wb_data);
      ex_imm_d    = bus.id_zext ? {16'h0000, bus.id_instr[15:0]}
                                : {{16{bus.id_instr[15]}}, bus.id_instr[15:0]};
      ex_rs_d     = id_rs;
      ex_rt_d     = id_rt;
      ex_rd_d     = bus.id_instr[15:11];
      ex_shamt_d  = bus.id_instr[10:6];
      ex_ctrl_d   = bus.id_ctrl;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_pc_q     <= 32'd0;
      ex_rs_val_q <= 32'd0;
      ex_rt_val_q <= 32'd0;
      ex_imm_q    <= 32'd0;
      ex_rs_q     <= 5'd0;
      ex_rt_q     <= 5'd0;
      ex_rd_q     <= 5'd0;
      ex_shamt_q  <= 5'd0;
      ex_ctrl_q   <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_pc_q     <= ex_pc_d;
      ex_rs_val_q <= ex_rs_val_d;
      ex_rt_val_q <= ex_rt_val_d;
      ex_imm_q    <= ex_imm_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_rd_q     <= ex_rd_d;
      ex_shamt_q  <= ex_shamt_d;
      ex_ctrl_q   <= ex_ctrl_d;
    end
  end

  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_pc     = ex_pc_q;
  assign bus.ex_rs_val = ex_rs_val_q;
  assign bus.ex_rt_val = ex_rt_val_q;
  assign bus.ex_imm    = ex_imm_q;
  assign bus.ex_rs     = ex_rs_q;
  assign bus.ex_rt     = ex_rt_q;
  assign bus.ex_rd     = ex_rd_q;
  assign bus.ex_shamt  = ex_shamt_q;
  assign bus.ex_ctrl   = ex_ctrl_q;
endmodule
